// File: rtl/int_sequencer.sv
// rtl/int_sequencer.sv - interrupt front-end for the 6502C control FSM
// Synchronises RES/NMI/IRQ pins, qualifies reset width, arbitrates at SYNC&RDY and holds the request until ack.
module int_sequencer #(
   parameter int SYNC_STAGES = 2,
   parameter int RST_MIN     = 4,
   parameter int ACK_TIMEOUT = 15
) (
   input  logic        phi1,
   input  logic        rst,
   input  logic        res_n,
   input  logic        nmi_n,
   input  logic        irq_n,
   input  logic        iflag,
   input  logic        sync,
   input  logic        rdy,
   input  logic        int_ack,
   output logic [3:0]  int_req,
   output logic        force_brk,
   output logic [15:0] vec_addr,
   output logic        nmi_pend,
   output logic        ack_err
);

   typedef enum logic {S_IDLE, S_SERVE} state_t;
   typedef enum logic [1:0] {SRC_RST, SRC_NMI, SRC_IRQ, SRC_NONE} src_t;

   localparam logic [2:0]  RST_MIN_C = 3'(RST_MIN);
   localparam logic [3:0]  TO_C      = 4'(ACK_TIMEOUT);
   localparam logic [15:0] VEC_RST   = 16'hFFFC;
   localparam logic [15:0] VEC_NMI   = 16'hFFFA;
   localparam logic [15:0] VEC_IRQ   = 16'hFFFE;

   logic [SYNC_STAGES-1:0] r_res_sync;
   logic [SYNC_STAGES-1:0] r_nmi_sync;
   logic [SYNC_STAGES-1:0] r_irq_sync;
   logic                   r_nmi_prev;
   logic                   r_nmi_latch;
   logic                   r_rst_q;
   logic [2:0]             r_rst_cnt;
   logic [3:0]             r_to_cnt;
   state_t                 r_state;
   src_t                   r_src;
   logic [3:0]             r_int_req;
   logic                   r_force_brk;
   logic [15:0]            r_vec_addr;
   logic                   r_ack_err;

   logic w_res_s;
   logic w_nmi_s;
   logic w_irq_s;
   logic w_nmi_edge;
   logic w_irq_pend;
   logic w_rst_qual;
   logic w_sample;
   logic w_nmi_clr;
   logic w_rst_clr;
   src_t w_src;

   function automatic logic [3:0] req_of(input src_t s);
      case (s)
         SRC_RST: req_of = 4'b0001;
         SRC_NMI: req_of = 4'b0010;
         SRC_IRQ: req_of = 4'b0100;
         default: req_of = 4'b0000;
      endcase
   endfunction

   function automatic logic [15:0] vec_of(input src_t s);
      case (s)
         SRC_RST: vec_of = VEC_RST;
         SRC_NMI: vec_of = VEC_NMI;
         default: vec_of = VEC_IRQ;
      endcase
   endfunction

   always_ff @(posedge phi1) begin
      if (rst) begin
         r_res_sync <= '1;
         r_nmi_sync <= '1;
         r_irq_sync <= '1;
      end else begin
         r_res_sync <= {r_res_sync[SYNC_STAGES-2:0], res_n};
         r_nmi_sync <= {r_nmi_sync[SYNC_STAGES-2:0], nmi_n};
         r_irq_sync <= {r_irq_sync[SYNC_STAGES-2:0], irq_n};
      end
   end

   assign w_res_s    = r_res_sync[SYNC_STAGES-1];
   assign w_nmi_s    = r_nmi_sync[SYNC_STAGES-1];
   assign w_irq_s    = r_irq_sync[SYNC_STAGES-1];
   assign w_nmi_edge = r_nmi_prev & ~w_nmi_s;
   assign w_irq_pend = ~w_irq_s & ~iflag;
   assign w_rst_qual = w_res_s & (r_rst_cnt == RST_MIN_C);
   assign w_sample   = sync & rdy;
   assign w_nmi_clr  = (r_state == S_SERVE) & int_ack & (r_src == SRC_NMI) & ~w_rst_qual;
   assign w_rst_clr  = (r_state == S_SERVE) & int_ack & (r_src == SRC_RST) & ~w_rst_qual;

   always_comb begin
      w_src = SRC_NONE;
      if (r_rst_q)
         w_src = SRC_RST;
      else if (r_nmi_latch)
         w_src = SRC_NMI;
      else if (w_irq_pend)
         w_src = SRC_IRQ;
   end

   // A new edge arriving with the ack must survive, so set has priority over clear.
   always_ff @(posedge phi1) begin
      if (rst) begin
         r_nmi_prev  <= 1'b1;
         r_nmi_latch <= 1'b0;
         r_rst_q     <= 1'b1;
         r_rst_cnt   <= 3'd0;
      end else begin
         r_nmi_prev <= w_nmi_s;
         if (w_nmi_edge)
            r_nmi_latch <= 1'b1;
         else if (w_nmi_clr)
            r_nmi_latch <= 1'b0;
         if (w_rst_qual)
            r_rst_q <= 1'b1;
         else if (w_rst_clr)
            r_rst_q <= 1'b0;
         if (!w_res_s) begin
            if (r_rst_cnt != RST_MIN_C)
               r_rst_cnt <= r_rst_cnt + 3'd1;
         end else begin
            r_rst_cnt <= 3'd0;
         end
      end
   end

   always_ff @(posedge phi1) begin
      if (rst) begin
         r_state     <= S_SERVE;
         r_src       <= SRC_RST;
         r_int_req   <= 4'b0001;
         r_force_brk <= 1'b1;
         r_vec_addr  <= VEC_RST;
         r_to_cnt    <= 4'd0;
         r_ack_err   <= 1'b0;
      end else if (w_rst_qual) begin
         // Qualified reset pre-empts whatever is being served.
         r_state     <= S_SERVE;
         r_src       <= SRC_RST;
         r_int_req   <= 4'b0001;
         r_force_brk <= 1'b1;
         r_vec_addr  <= VEC_RST;
         r_to_cnt    <= 4'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_sample && (w_src != SRC_NONE)) begin
                  r_state     <= S_SERVE;
                  r_src       <= w_src;
                  r_int_req   <= req_of(w_src);
                  r_force_brk <= 1'b1;
                  r_vec_addr  <= vec_of(w_src);
                  r_to_cnt    <= 4'd0;
               end
            end
            S_SERVE: begin
               if (int_ack || (r_to_cnt == TO_C)) begin
                  r_state     <= S_IDLE;
                  r_int_req   <= 4'b0000;
                  r_force_brk <= 1'b0;
                  r_vec_addr  <= VEC_IRQ;
                  r_to_cnt    <= 4'd0;
                  if (!int_ack)
                     r_ack_err <= 1'b1;
               end else begin
                  r_to_cnt <= r_to_cnt + 4'd1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign int_req   = r_int_req;
   assign force_brk = r_force_brk;
   assign vec_addr  = r_vec_addr;
   assign nmi_pend  = r_nmi_latch;
   assign ack_err   = r_ack_err;

endmodule

// File: tb/tb_int_sequencer.sv
// tb/tb_int_sequencer.sv - directed table and sequence bench for int_sequencer
module tb_int_sequencer;

   logic        phi1 = 1'b0;
   logic        rst = 1'b1;
   logic        res_n = 1'b1;
   logic        nmi_n = 1'b1;
   logic        irq_n = 1'b1;
   logic        iflag = 1'b1;
   logic        sync = 1'b0;
   logic        rdy = 1'b1;
   logic        int_ack = 1'b0;
   logic [3:0]  int_req;
   logic        force_brk;
   logic [15:0] vec_addr;
   logic        nmi_pend;
   logic        ack_err;

   int n_checks = 0;
   int n_errors = 0;

   int_sequencer #(.SYNC_STAGES(2), .RST_MIN(4), .ACK_TIMEOUT(15)) dut (
      .phi1(phi1), .rst(rst), .res_n(res_n), .nmi_n(nmi_n), .irq_n(irq_n),
      .iflag(iflag), .sync(sync), .rdy(rdy), .int_ack(int_ack),
      .int_req(int_req), .force_brk(force_brk), .vec_addr(vec_addr),
      .nmi_pend(nmi_pend), .ack_err(ack_err)
   );

   always #5 phi1 = ~phi1;

   typedef struct {
      logic        sync;
      logic        rdy;
      logic        irq_n;
      logic        iflag;
      logic        ack;
      logic [3:0]  req;
      logic        fb;
      logic [15:0] va;
      logic        pend;
      logic        err;
   } vec_t;

   vec_t tbl[16];

   task automatic tick();
      @(posedge phi1);
      #1;
   endtask

   task automatic chk(input string nm, input logic [3:0] req, input logic fb,
                      input logic [15:0] va, input logic pend, input logic err);
      n_checks += 5;
      if (int_req !== req) begin
         n_errors++;
         $display("FAIL %s int_req got %b want %b", nm, int_req, req);
      end
      if (force_brk !== fb) begin
         n_errors++;
         $display("FAIL %s force_brk got %b want %b", nm, force_brk, fb);
      end
      if (vec_addr !== va) begin
         n_errors++;
         $display("FAIL %s vec_addr got %h want %h", nm, vec_addr, va);
      end
      if (nmi_pend !== pend) begin
         n_errors++;
         $display("FAIL %s nmi_pend got %b want %b", nm, nmi_pend, pend);
      end
      if (ack_err !== err) begin
         n_errors++;
         $display("FAIL %s ack_err got %b want %b", nm, ack_err, err);
      end
   endtask

   task automatic hold(input int n, input string nm, input logic [3:0] req, input logic fb,
                       input logic [15:0] va, input logic pend, input logic err);
      for (int i = 0; i < n; i++) begin
         tick();
         chk(nm, req, fb, va, pend, err);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      //     sync rdy irq_n iflag ack   req     fb  vec       pend err
      tbl[0]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0001, 1'b1, 16'hFFFC, 1'b0, 1'b0};
      tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0001, 1'b1, 16'hFFFC, 1'b0, 1'b0};
      tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0001, 1'b1, 16'hFFFC, 1'b0, 1'b0};
      tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0001, 1'b1, 16'hFFFC, 1'b0, 1'b0};
      tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b0, 16'hFFFE, 1'b0, 1'b0};
      tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b0, 16'hFFFE, 1'b0, 1'b0};
      tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 16'hFFFE, 1'b0, 1'b0};
      tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 16'hFFFE, 1'b0, 1'b0};
      tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 16'hFFFE, 1'b0, 1'b0};
      tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 16'hFFFE, 1'b0, 1'b0};
      tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 16'hFFFE, 1'b0, 1'b0};
      tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b1, 16'hFFFE, 1'b0, 1'b0};
      tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0100, 1'b1, 16'hFFFE, 1'b0, 1'b0};
      tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0100, 1'b1, 16'hFFFE, 1'b0, 1'b0};
      tbl[14] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, 16'hFFFE, 1'b0, 1'b0};
      tbl[15] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 16'hFFFE, 1'b0, 1'b0};

      // power-up reset
      tick();
      chk("reset", 4'b0001, 1'b1, 16'hFFFC, 1'b0, 1'b0);
      rst = 1'b0;

      for (int i = 0; i < 16; i++) begin
         sync    = tbl[i].sync;
         rdy     = tbl[i].rdy;
         irq_n   = tbl[i].irq_n;
         iflag   = tbl[i].iflag;
         int_ack = tbl[i].ack;
         tick();
         chk($sformatf("table[%0d]", i), tbl[i].req, tbl[i].fb, tbl[i].va, tbl[i].pend, tbl[i].err);
      end
      sync = 1'b0; rdy = 1'b1; int_ack = 1'b0; iflag = 1'b1;

      // ack arriving on the timeout cycle wins
      irq_n = 1'b0; iflag = 1'b0;
      hold(2, "to_race_setup", 4'b0000, 1'b0, 16'hFFFE, 1'b0, 1'b0);
      sync = 1'b1;
      hold(1, "to_race_enter", 4'b0100, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      sync = 1'b0; irq_n = 1'b1; iflag = 1'b1;
      hold(15, "to_race_wait", 4'b0100, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      int_ack = 1'b1;
      hold(1, "to_race_ack", 4'b0000, 1'b0, 16'hFFFE, 1'b0, 1'b0);
      int_ack = 1'b0;

      // NMI edge through the synchroniser and its service
      nmi_n = 1'b0;
      hold(2, "nmi_sync", 4'b0000, 1'b0, 16'hFFFE, 1'b0, 1'b0);
      hold(1, "nmi_latched", 4'b0000, 1'b0, 16'hFFFE, 1'b1, 1'b0);
      sync = 1'b1;
      hold(1, "nmi_serve", 4'b0010, 1'b1, 16'hFFFA, 1'b1, 1'b0);
      sync = 1'b0; int_ack = 1'b1;
      hold(1, "nmi_ack", 4'b0000, 1'b0, 16'hFFFE, 1'b0, 1'b0);
      int_ack = 1'b0;

      // NMI and IRQ pending together
      nmi_n = 1'b1;
      hold(3, "nmi_release", 4'b0000, 1'b0, 16'hFFFE, 1'b0, 1'b0);
      nmi_n = 1'b0; irq_n = 1'b0; iflag = 1'b0;
      hold(2, "both_sync", 4'b0000, 1'b0, 16'hFFFE, 1'b0, 1'b0);
      hold(1, "both_latched", 4'b0000, 1'b0, 16'hFFFE, 1'b1, 1'b0);
      sync = 1'b1;
      hold(1, "both_nmi_wins", 4'b0010, 1'b1, 16'hFFFA, 1'b1, 1'b0);
      sync = 1'b0; int_ack = 1'b1;
      hold(1, "both_nmi_ack", 4'b0000, 1'b0, 16'hFFFE, 1'b0, 1'b0);
      int_ack = 1'b0; sync = 1'b1;
      hold(1, "both_irq_next", 4'b0100, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      sync = 1'b0; int_ack = 1'b1;
      hold(1, "both_irq_ack", 4'b0000, 1'b0, 16'hFFFE, 1'b0, 1'b0);
      int_ack = 1'b0; irq_n = 1'b1; iflag = 1'b1;

      // timeout keeps the NMI latch and sets the sticky error
      nmi_n = 1'b1;
      hold(3, "to_release", 4'b0000, 1'b0, 16'hFFFE, 1'b0, 1'b0);
      nmi_n = 1'b0;
      hold(2, "to_sync", 4'b0000, 1'b0, 16'hFFFE, 1'b0, 1'b0);
      hold(1, "to_latched", 4'b0000, 1'b0, 16'hFFFE, 1'b1, 1'b0);
      sync = 1'b1;
      hold(1, "to_enter", 4'b0010, 1'b1, 16'hFFFA, 1'b1, 1'b0);
      sync = 1'b0;
      hold(15, "to_wait", 4'b0010, 1'b1, 16'hFFFA, 1'b1, 1'b0);
      hold(1, "to_expire", 4'b0000, 1'b0, 16'hFFFE, 1'b1, 1'b1);

      // new NMI edge in the same cycle as the NMI ack
      sync = 1'b1;
      hold(1, "race_enter", 4'b0010, 1'b1, 16'hFFFA, 1'b1, 1'b1);
      sync = 1'b0; nmi_n = 1'b1;
      hold(3, "race_release", 4'b0010, 1'b1, 16'hFFFA, 1'b1, 1'b1);
      nmi_n = 1'b0;
      hold(2, "race_sync", 4'b0010, 1'b1, 16'hFFFA, 1'b1, 1'b1);
      int_ack = 1'b1;
      hold(1, "race_ack", 4'b0000, 1'b0, 16'hFFFE, 1'b1, 1'b1);
      int_ack = 1'b0; sync = 1'b1;
      hold(1, "race_reserve", 4'b0010, 1'b1, 16'hFFFA, 1'b1, 1'b1);
      sync = 1'b0; int_ack = 1'b1;
      hold(1, "race_clear", 4'b0000, 1'b0, 16'hFFFE, 1'b0, 1'b1);
      int_ack = 1'b0;

      // short reset pulse is ignored
      res_n = 1'b0;
      hold(2, "glitch_low", 4'b0000, 1'b0, 16'hFFFE, 1'b0, 1'b1);
      res_n = 1'b1;
      hold(4, "glitch_high", 4'b0000, 1'b0, 16'hFFFE, 1'b0, 1'b1);

      // qualified reset aborts an IRQ service
      irq_n = 1'b0; iflag = 1'b0;
      hold(2, "abort_setup", 4'b0000, 1'b0, 16'hFFFE, 1'b0, 1'b1);
      sync = 1'b1;
      hold(1, "abort_irq", 4'b0100, 1'b1, 16'hFFFE, 1'b0, 1'b1);
      sync = 1'b0; res_n = 1'b0;
      hold(6, "abort_low", 4'b0100, 1'b1, 16'hFFFE, 1'b0, 1'b1);
      res_n = 1'b1;
      hold(2, "abort_rise", 4'b0100, 1'b1, 16'hFFFE, 1'b0, 1'b1);
      hold(1, "abort_rst", 4'b0001, 1'b1, 16'hFFFC, 1'b0, 1'b1);
      irq_n = 1'b1; iflag = 1'b1; int_ack = 1'b1;
      hold(1, "abort_ack", 4'b0000, 1'b0, 16'hFFFE, 1'b0, 1'b1);
      int_ack = 1'b0; sync = 1'b1;
      hold(1, "abort_rstq_clear", 4'b0000, 1'b0, 16'hFFFE, 1'b0, 1'b1);
      sync = 1'b0;

      // rst clears the sticky error
      rst = 1'b1;
      hold(1, "final_reset", 4'b0001, 1'b1, 16'hFFFC, 1'b0, 1'b0);
      rst = 1'b0;

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
